// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one DATA_WIDTH word in over valid/ready,
// one bit per transfer out over a serial valid/ready stream, no bubble between words.
module piso_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_last,
    input  logic                  ser_ready,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] shifted;

    // Outputs decode straight from state flops; only in_ready sees ser_ready.
    assign ser_valid = (state_q == SHIFT);
    assign ser_last  = ser_valid & (cnt_q == '0);
    assign ser_out   = LSB_FIRST ? shift_q[0] : shift_q[DATA_WIDTH-1];
    assign busy      = ser_valid;
    assign in_ready  = ~reset & ((state_q == IDLE) | (ser_last & ser_ready));

    assign accept  = in_valid & in_ready;
    assign xfer    = ser_valid & ser_ready;
    assign shifted = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (cnt_q != '0) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else if (accept) begin
                        // Last bit leaves while next word loads: no idle cycle.
                        shift_d = in_data;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        shift_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parameterized parallel-in serial-out transmitter: accepts a DATA_WIDTH word over a valid/ready handshake and emits it one bit per transfer on a serial valid/ready stream.
- Counterpart to the team's parallel-load register blocks. Sits between a parallel datapath (register/FIFO output) and a serial link or bit-level consumer.
- Supports back-to-back words with no idle bubble and downstream backpressure at any bit.

Parameters:
- DATA_WIDTH, 8, word width in bits. Legal values are 2 and above; the bench checks this at elaboration.
- LSB_FIRST, 0, bit order. 0 sends bit DATA_WIDTH-1 first; 1 sends bit 0 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH  parallel word to send
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a word this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out is valid
- ser_last  output  1  ser_out is the final bit of the word
- ser_ready  input  1  downstream accepts ser_out this cycle
- busy  output  1  a word is in progress; equals ser_valid

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high. All state is cleared immediately on reset assertion.
- Internal state:
  - state, two values: IDLE or SHIFT.
  - shift_reg, DATA_WIDTH bits.
  - bit_cnt, $clog2(DATA_WIDTH) bits, holding bits remaining minus 1.
- Reset values: state=IDLE, shift_reg=0, bit_cnt=0. Outputs during and after reset: ser_out=0, ser_valid=0, ser_last=0, busy=0. in_ready=0 while reset is high, and 1 from the first cycle after release.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Serial transfer = ser_valid & ser_ready.
  - Both take effect on the rising clk edge.
- Output decode:
  - ser_valid = (state==SHIFT).
  - ser_last = ser_valid & (bit_cnt==0).
  - ser_out = shift_reg[DATA_WIDTH-1] when LSB_FIRST=0, else shift_reg[0]. ser_out is 0 in IDLE because the register is cleared when a word completes.
- in_ready = (state==IDLE) | (ser_last & ser_ready). This is a combinational path from ser_ready to in_ready; it is the only one allowed.
- IDLE:
  - On accept: shift_reg<=in_data, bit_cnt<=DATA_WIDTH-1, state<=SHIFT.
  - Latency: the first bit is valid in the cycle after the accept edge.
- SHIFT, with transfer and bit_cnt!=0: shift shift_reg by one toward the output end, zero-filling, and decrement bit_cnt.
- SHIFT, with transfer and bit_cnt==0 (last bit):
  - If an accept occurs in the same cycle: reload shift_reg, set bit_cnt=DATA_WIDTH-1, stay in SHIFT. There is no bubble; the next word's first bit is valid the next cycle.
  - Otherwise: shift_reg<=0, state<=IDLE.
- SHIFT, with ser_ready=0: all state holds. ser_out, ser_valid and ser_last stay stable until the transfer.
- While SHIFT and not on the last transfer, in_ready=0. in_valid is ignored, and in_data is not sampled.
- A word of DATA_WIDTH bits needs exactly DATA_WIDTH transfers. With ser_ready held high, throughput is one word per DATA_WIDTH cycles.
- Reset mid-word: the partial word is discarded, ser_valid drops immediately (asynchronous), and nothing resumes after release.
- in_valid high during reset is not accepted. The first accept is possible on the first edge after release.
- Upstream must keep in_valid and in_data stable until accept. The block does not check this.

Test Plan:
- DATA_WIDTH=8, LSB_FIRST=0, ser_ready=1, accept 0x0F at edge k -> from cycle k+1: ser_out=0,0,0,0,1,1,1,1 on 8 consecutive cycles. ser_last is high only on the 8th. ser_valid drops and in_ready rises at cycle k+9.
- LSB_FIRST=1, accept 0x0F -> ser_out=1,1,1,1,0,0,0,0, with ser_last on the 8th bit.
- Backpressure: send 0xA5 MSB-first and hold ser_ready=0 for 3 cycles while the 3rd bit (1) is presented -> ser_out=1 with ser_valid=1 held for those 3 cycles. Full sequence is 1,0,1,0,0,1,0,1 with no lost or repeated bit.
- Back-to-back: in_valid held with 0xA5 then 0x3C, ser_ready=1 -> 16 contiguous ser_valid cycles with bits 10100101 00111100. ser_last is high on cycles 8 and 16. in_ready is high exactly in IDLE before word 1 and on the last-bit cycle of word 1.
- Busy ignore: while word 0xA5 is at bit 4, drive in_valid=1 with 0xFF -> in_ready=0 and 0xA5 completes unchanged. 0xFF is accepted on 0xA5's last-bit cycle and follows it.
- Reset mid-word: assert reset at bit 5 of 0x3C -> ser_valid, ser_last and ser_out go to 0 immediately. After release: in_ready=1, ser_valid=0, and no residual bits emerge.
